booth_seq_ctrl: RTL and testbench
=================================

BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; WIDTH SHALL be even and at least 4.
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have in_valid  input  1  operand pair offered.
REQ-005 SHALL have in_ready  output  1  operand pair accepted when high together with in_valid.
REQ-006 SHALL have Multiplicant  input  WIDTH  signed two's-complement multiplicand.
REQ-007 SHALL have Multiplier  input  WIDTH  signed two's-complement multiplier.
REQ-008 SHALL have out_valid  output  1  Product holds a result.
REQ-009 SHALL have out_ready  input  1  consumer takes the result.
REQ-010 SHALL have Product  output  2*WIDTH  signed product.
REQ-011 SHALL have busy  output  1  high in CALC and DONE.

Function
REQ-012 SHALL compute Product = Multiplicant * Multiplier with both operands signed, exact in 2*WIDTH bits and without overflow, including -2^(WIDTH-1) * -2^(WIDTH-1).
REQ-013 SHALL use an FSM with three states: IDLE, CALC and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE.
REQ-015 SHALL drive out_valid = 1 only in DONE.
REQ-016 SHALL, on a clock edge with in_valid & in_ready, register both operands, append a 0 below the multiplier LSB, clear the accumulator, clear the digit counter and enter CALC.
REQ-017 SHALL, in CALC, process one radix-4 Booth digit per clock, from window {y(2k+1), y(2k), y(2k-1)} with y(-1) = 0.
REQ-018 SHALL encode the digit as 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
REQ-019 SHALL sign-extend the partial product to 2*WIDTH bits, shift it left by 2k and add it to the accumulator modulo 2^(2*WIDTH).
REQ-020 SHALL, without the early-termination feature, leave CALC after digit WIDTH/2-1, so out_valid rises exactly WIDTH/2 cycles after the accepting edge (8 for WIDTH = 16).
REQ-021 SHALL hold Product and out_valid stable in DONE until out_ready = 1, then return to IDLE on that edge.
REQ-022 SHALL keep Product equal to the last result in IDLE, and not update it during CALC.
REQ-023 SHALL ignore in_valid while busy: no capture and no effect on the running operation.
REQ-024 SHALL not accept a new operand pair on the same edge that DONE -> IDLE occurs; the earliest accept is the next edge.
REQ-025 SHALL ignore out_ready outside DONE.

Reset
REQ-026 SHALL, on rst = 1 at a clock edge, enter IDLE with in_ready = 1, out_valid = 0, busy = 0, Product = 0, accumulator = 0 and digit counter = 0.
REQ-027 SHALL, when rst is asserted mid-CALC or in DONE, abort the operation and discard the result, with no out_valid pulse after reset.
REQ-028 SHALL give rst priority over every other input on the same edge.

Configuration
REQ-029 SHALL, when macro BOOTH_EARLY_TERM_EN is defined, end CALC on the edge that processes digit k if multiplier bits y(2k+1) through y(WIDTH-1) are all equal, meaning all remaining digits are zero; the result is then identical to the full computation.
REQ-030 SHALL, when BOOTH_EARLY_TERM_EN is defined, take at least 1 and at most WIDTH/2 CALC cycles.
REQ-031 SHALL, when BOOTH_EARLY_TERM_EN is undefined, have fixed latency per REQ-020 and contain no early-termination logic.

Verification
REQ-032 SHALL cover: Multiplicant = 3, Multiplier = 5 -> Product = 0x0000000F, out_valid 8 cycles after accept (2 cycles with BOOTH_EARLY_TERM_EN).
REQ-033 SHALL cover: 0x8000 * 0x8000 -> Product = 0x40000000; 0x7FFF * 0xFFFF -> Product = 0xFFFF8001.
REQ-034 SHALL cover: Multiplier = 0 with BOOTH_EARLY_TERM_EN -> Product = 0, out_valid 1 cycle after accept.
REQ-035 SHALL cover: in_valid held high with new operands during CALC -> in_ready = 0, the result matches the first operands, and the second pair is accepted only after DONE -> IDLE.
REQ-036 SHALL cover: out_ready held 0 for 5 cycles in DONE -> Product and out_valid stable, and IDLE on the first edge with out_ready = 1.
REQ-037 SHALL cover: rst pulsed at CALC cycle 4 -> next cycle IDLE, Product = 0, out_valid = 0, and no later out_valid until a new accept.

Source files
------------

// File: rtl/booth_seq_ctrl_if.sv
// Operand/result handshake bundle for booth_seq_ctrl.
// Master drives operands and out_ready; slave is the multiplier.
interface booth_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     Multiplicant;
    logic [WIDTH-1:0]     Multiplier;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   Product;
    logic                 busy;

    modport master (
        output in_valid,
        output Multiplicant,
        output Multiplier,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Product,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  Multiplicant,
        input  Multiplier,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Product,
        output busy
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth signed multiplier, one digit per clock.
// Define BOOTH_EARLY_TERM_EN to stop once the remaining digits are all zero.
module booth_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    booth_seq_ctrl_if.slave   bus
);
    localparam int PW = 2 * WIDTH;
    localparam int ND = WIDTH / 2;
    localparam int CW = $clog2(ND);
    localparam logic [CW-1:0] LAST = CW'(ND - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // mc carries the multiplicand pre-scaled by 4^k for the current digit.
    logic [PW-1:0]   mc;
    // mq[2:0] is always the current Booth window {y(2k+1), y(2k), y(2k-1)}.
    logic [WIDTH:0]  mq;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   sum;
    logic [PW-1:0]   prod;
    logic [CW-1:0]   cnt;
    logic            last;

    // Booth digit recode into a signed, pre-shifted partial product
    always_comb begin
        pp = '0;
        case (mq[2:0])
            3'b001, 3'b010: pp = mc;
            3'b011:         pp = mc << 1;
            3'b100:         pp = -(mc << 1);
            3'b101, 3'b110: pp = -mc;
            default:        pp = '0;
        endcase
    end

    assign sum = acc + pp;

`ifdef BOOTH_EARLY_TERM_EN
    // Upper bits of mq all equal means every later window is 000 or 111.
    logic rest_same;
    assign rest_same = (&mq[WIDTH:2]) | ~(|mq[WIDTH:2]);
    assign last      = (cnt == LAST) || rest_same;
`else
    assign last = (cnt == LAST);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.in_valid)  state_nxt = CALC;
            CALC: if (last)          state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Operand capture, digit iteration and result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            mc   <= '0;
            mq   <= '0;
            acc  <= '0;
            cnt  <= '0;
            prod <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mc  <= {{WIDTH{bus.Multiplicant[WIDTH-1]}},
                                bus.Multiplicant};
                        mq  <= {bus.Multiplier, 1'b0};
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    acc <= sum;
                    mc  <= mc << 2;
                    mq  <= {{2{mq[WIDTH]}}, mq[WIDTH:2]};
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        prod <= sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == CALC) || (state == DONE);
    assign bus.Product   = prod;
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (WIDTH = 16).
// Vector table plus corner sequences, results checked through a queue.
module tb_booth_seq_ctrl;
    localparam int W = 16;

    logic clk;
    logic rst;

    booth_seq_ctrl_if #(.WIDTH(W)) bus ();

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] sb_q [$];
    int          passed;
    int          total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] b);
`ifdef BOOTH_EARLY_TERM_EN
        for (int k = 0; k < 8; k++) begin
            logic same;
            same = 1'b1;
            for (int i = 2 * k + 1; i < 16; i++) begin
                if (b[i] != b[15]) same = 1'b0;
            end
            if (same) return k + 1;
        end
        return 8;
`else
        return 8;
`endif
    endfunction

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic check_result(input string nm);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            chk({nm, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk(nm, bus.Product, e);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] p, input int hold);
        int n;
        bus.in_valid     = 1'b1;
        bus.Multiplicant = a;
        bus.Multiplier   = b;
        bus.out_ready    = 1'b0;
        step();
        sb_q.push_back(p);
        bus.in_valid = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        chk("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
        wait_out(n);
        chk("latency", 32'(n), 32'(exp_lat(b)));
        check_result("product");
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_product", bus.Product, p);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_product_kept", bus.Product, p);
    endtask

    initial begin
        int          n;
        logic        seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] rp;

        passed = 0;
        total  = 0;

        tbl[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        tbl[1] = '{16'h8000, 16'h8000, 32'h40000000};
        tbl[2] = '{16'h7FFF, 16'hFFFF, 32'hFFFF8001};
        tbl[3] = '{16'h0000, 16'h1234, 32'h00000000};
        tbl[4] = '{16'h1234, 16'h0000, 32'h00000000};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
        tbl[6] = '{16'h8000, 16'h7FFF, 32'hC0008000};
        tbl[7] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        tbl[8] = '{16'h0005, 16'hFFFD, 32'hFFFFFFF1};
        tbl[9] = '{16'h1234, 16'h5678, 32'h06260060};

        rst              = 1'b1;
        bus.in_valid     = 1'b1;
        bus.out_ready    = 1'b0;
        bus.Multiplicant = 16'h1111;
        bus.Multiplier   = 16'h2222;
        step();
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_product", bus.Product, 32'd0);
        step();

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].p, 0);
        end

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rp = $signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb});
            run_op(ra, rb, rp, 0);
        end

        run_op(16'hFF9C, 16'h0007, 32'hFFFFFD44, 5);

        bus.in_valid     = 1'b1;
        bus.Multiplicant = 16'd3;
        bus.Multiplier   = 16'd5;
        step();
        sb_q.push_back(32'd15);
        bus.Multiplicant = 16'd7;
        bus.Multiplier   = 16'd9;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            step();
            n++;
        end
        chk("stall_latency", 32'(n), 32'(exp_lat(16'd5)));
        check_result("stall_first_result");
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("no_accept_on_done_edge", 32'(bus.busy), 32'd0);
        chk("idle_after_done", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        step();
        sb_q.push_back(32'd63);
        bus.in_valid = 1'b0;
        chk("second_accept", 32'(bus.busy), 32'd1);
        wait_out(n);
        chk("second_latency", 32'(n), 32'(exp_lat(16'd9)));
        check_result("second_result");
        step();
        bus.out_ready = 1'b0;
        chk("second_idle", 32'(bus.in_ready), 32'd1);

        bus.in_valid     = 1'b1;
        bus.Multiplicant = 16'h1234;
        bus.Multiplier   = 16'h5678;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_product", bus.Product, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort_no_out_valid", 32'(seen), 32'd0);

        bus.in_valid     = 1'b1;
        bus.Multiplicant = 16'h0010;
        bus.Multiplier   = 16'h0020;
        step();
        bus.in_valid = 1'b0;
        wait_out(n);
        chk("done_reached", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("done_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("done_rst_product", bus.Product, 32'd0);

        run_op(16'hFFFE, 16'h0003, 32'hFFFFFFFA, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
